// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared definitions for the input filtering blocks. The state encoding is
//   fixed at STABLE=1'b0 and QUALIFY=1'b1 so that later filter blocks can
//   reuse the same encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package debounce_pkg;

    // Two-state filter FSM: STABLE holds the accepted level, QUALIFY is
    // counting consecutive samples of a candidate new level.
    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } db_state_e;

    localparam logic STATE_STABLE_ENC  = 1'b0;
    localparam logic STATE_QUALIFY_ENC = 1'b1;

endpackage : debounce_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for one asynchronous input. Both flops reset
//   asynchronously to RESET_LEVEL so that nothing downstream sees a spurious
//   change of level when reset is released.
// Ports
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   d      in   1  raw asynchronous input
//   q      out  1  synchronized level (second flop)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_r;
    logic s2_r;

    // Synchronizer chain: s1 captures the raw input, s2 feeds the logic that
    // follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= RESET_LEVEL;
            s2_r <= RESET_LEVEL;
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
        end
    end

    assign q = s2_r;

endmodule : sync_2ff

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//   Turns a bouncing push-button or switch input into a clean, synchronous
//   level. The input passes through a two-flop synchronizer. A new level is
//   accepted only after the synchronized sample has differed from y for
//   STABLE_CYCLES consecutive clocks. Any sample that matches y again
//   restarts the qualification from zero.
//   Optional macro INPUT_DEBOUNCER_EDGE_EN adds the registered one-cycle
//   rise/fall pulses. Without the macro those ports and their flops are
//   absent.
// Ports
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   a      in   1  raw asynchronous input (may bounce)
//   y      out  1  debounced level (registered)
//   busy   out  1  high while a candidate level change is being qualified
//   rise   out  1  one-cycle pulse when y goes 0->1 (INPUT_DEBOUNCER_EDGE_EN)
//   fall   out  1  one-cycle pulse when y goes 1->0 (INPUT_DEBOUNCER_EDGE_EN)
// -----------------------------------------------------------------------------
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 16,
    localparam int  CNT_W         = $clog2(STABLE_CYCLES + 1),
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    output logic y,
    output logic busy
`ifdef INPUT_DEBOUNCER_EDGE_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    // The last count value before acceptance. The counter therefore stays in
    // 0..STABLE_CYCLES-1 and cannot wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             s2;
    db_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             y_r;
    logic             busy_r;
    logic             take_s;

    sync_2ff #(
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (a),
        .q     (s2)
    );

    // Acceptance strobe: y takes s2 on this edge. With STABLE_CYCLES==1 the
    // first differing sample is accepted directly from STABLE.
    always_comb begin
        take_s = 1'b0;
        if (s2 != y_r) begin
            if ((state_r == STABLE) && (STABLE_CYCLES == 1)) begin
                take_s = 1'b1;
            end else if ((state_r == QUALIFY) && (cnt_r == CNT_LAST)) begin
                take_s = 1'b1;
            end else begin
                take_s = 1'b0;
            end
        end else begin
            take_s = 1'b0;
        end
    end

    // Filter FSM with its counter, the accepted level and the busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= STABLE;
            cnt_r   <= CNT_ZERO;
            y_r     <= RESET_LEVEL;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                STABLE: begin
                    if (take_s) begin
                        y_r    <= s2;
                        cnt_r  <= CNT_ZERO;
                        busy_r <= 1'b0;
                    end else if (s2 != y_r) begin
                        state_r <= QUALIFY;
                        cnt_r   <= CNT_ONE;
                        busy_r  <= 1'b1;
                    end else begin
                        cnt_r  <= CNT_ZERO;
                        busy_r <= 1'b0;
                    end
                end
                QUALIFY: begin
                    if (s2 == y_r) begin
                        // Bounced back to the accepted level: drop the candidate.
                        state_r <= STABLE;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end else if (take_s) begin
                        y_r     <= s2;
                        state_r <= STABLE;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r  <= cnt_r + CNT_ONE;
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= STABLE;
                    cnt_r   <= CNT_ZERO;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign y    = y_r;
    assign busy = busy_r;

`ifdef INPUT_DEBOUNCER_EDGE_EN
    logic rise_r;
    logic fall_r;

    // Edge pulses are set on the same edge as y, so each pulse is high in the
    // cycle in which y first shows its new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= take_s & s2;
            fall_r <= take_s & ~s2;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;
`else
    // This build has no edge outputs and no edge flops.
`endif

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//   Directed bench for input_debouncer.
//   dut  : STABLE_CYCLES=4, RESET_LEVEL=0
//   dut2 : STABLE_CYCLES=1, RESET_LEVEL=1
//   Each observation packs {y, busy, rise, fall}. The rise and fall bits are
//   expected only when INPUT_DEBOUNCER_EDGE_EN is defined. Without the macro
//   they are tied to 0 here, and their expected values are 0 as well.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

`ifdef INPUT_DEBOUNCER_EDGE_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic a     = 1'b0;
    logic a2    = 1'b1;
    logic y, busy, rise, fall;
    logic y2, busy2, rise2, fall2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    input_debouncer #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .y     (y),
        .busy  (busy)
`ifdef INPUT_DEBOUNCER_EDGE_EN
        ,
        .rise  (rise),
        .fall  (fall)
`endif
    );

    input_debouncer #(.STABLE_CYCLES(1), .RESET_LEVEL(1'b1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a2),
        .y     (y2),
        .busy  (busy2)
`ifdef INPUT_DEBOUNCER_EDGE_EN
        ,
        .rise  (rise2),
        .fall  (fall2)
`endif
    );

`ifndef INPUT_DEBOUNCER_EDGE_EN
    assign rise  = 1'b0;
    assign fall  = 1'b0;
    assign rise2 = 1'b0;
    assign fall2 = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: {y,busy,rise,fall} got %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp4(input logic ey, input logic eb,
                                        input logic er, input logic ef);
        return {ey, eb, er & EDGE, ef & EDGE};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offset 0 is the edge that first samples the new level. busy is high
    // after offsets 2..4. y and the pulse change after offset 5.
    task automatic qualify_seq(input string tag, input logic lvl);
        a = lvl;
        for (int off = 0; off <= 6; off++) begin
            tick();
            check_eq($sformatf("%s_e%0d", tag, off), {y, busy, rise, fall},
                     exp4((off >= 5) ? lvl : ~lvl, (off >= 2) && (off <= 4),
                          (off == 5) && lvl, (off == 5) && !lvl));
        end
    endtask

    initial begin
        // 1: asynchronous reset with a=1 and no clock edge yet.
        a  = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_eq("reset_async", {y, busy, rise, fall}, exp4(1'b0, 1'b0, 1'b0, 1'b0));
        check_eq("reset_async2", {y2, busy2, rise2, fall2}, exp4(1'b1, 1'b0, 1'b0, 1'b0));
        a = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check_eq("idle", {y, busy, rise, fall}, exp4(1'b0, 1'b0, 1'b0, 1'b0));
        check_eq("idle2_no_pulse", {y2, busy2, rise2, fall2}, exp4(1'b1, 1'b0, 1'b0, 1'b0));

        // 3: a is high for only 3 samples, so y must not change.
        a = 1'b1;
        for (int off = 0; off <= 7; off++) begin
            tick();
            check_eq($sformatf("bounce_e%0d", off), {y, busy, rise, fall},
                     exp4(1'b0, (off >= 2) && (off <= 4), 1'b0, 1'b0));
            if (off == 2) a = 1'b0;
        end
        repeat (2) tick();

        // 2 and 3 tail: clean rise. 4: clean fall. Then rise again.
        qualify_seq("rise", 1'b1);
        qualify_seq("fall", 1'b0);
        qualify_seq("rise2", 1'b1);

        // 5: reset while a fall is being qualified.
        a = 1'b0;
        repeat (3) tick();
        check_eq("midq_busy", {y, busy, rise, fall}, exp4(1'b1, 1'b1, 1'b0, 1'b0));
        #2 rst_n = 1'b0;
        #1;
        check_eq("midq_reset", {y, busy, rise, fall}, exp4(1'b0, 1'b0, 1'b0, 1'b0));
        a = 1'b1;
        repeat (2) tick();
        check_eq("midq_held", {y, busy, rise, fall}, exp4(1'b0, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;
        qualify_seq("restart", 1'b1);

        // 6: STABLE_CYCLES=1 with RESET_LEVEL=1. y follows the input 2 edges
        // later and busy never rises.
        a2 = 1'b0;
        for (int off = 0; off <= 3; off++) begin
            tick();
            check_eq($sformatf("sc1_fall_e%0d", off), {y2, busy2, rise2, fall2},
                     exp4((off >= 2) ? 1'b0 : 1'b1, 1'b0, 1'b0, off == 2));
        end
        a2 = 1'b1;
        for (int off = 0; off <= 3; off++) begin
            tick();
            check_eq($sformatf("sc1_rise_e%0d", off), {y2, busy2, rise2, fall2},
                     exp4((off >= 2) ? 1'b1 : 1'b0, 1'b0, off == 2, 1'b0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_input_debouncer
